controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Multi-cycle control FSM for the 3-bit-opcode processor.
- Replaces single-cycle decode by sequencing each instruction through fetch, decode, execute, memory and write-back over several clocks.
- Shares one handshaked memory port between instruction fetch and data access.
- Drives the existing datapath control nets (ULAOp, ULAFonte, LerMem, EscMem, EscReg, EscPC, RegFonte, SelDest) plus the new multi-cycle nets IREsc, IouD and PCFonte.

Parameters:
- MAX_ESPERA, 15: maximum consecutive cycles a memory access may wait for MemPronta before a timeout error. Range 1..255.
- LARG_CONT, 8: width of the wait counter. Must hold MAX_ESPERA.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Opcode  in  3  opcode field from the instruction register; valid from DECODIFICA onward.
- Zero  in  1  ALU zero flag, used by beqz.
- MemPronta  in  1  memory handshake; the access completes in the cycle it is 1.
- IREsc  out  1  instruction register write enable.
- IouD  out  1  memory address select: 0 = PC, 1 = ALU result.
- LerMem  out  1  memory read request.
- EscMem  out  1  memory write request.
- ULAOp  out  2  ALU operation class.
- ULAFonte  out  2  ALU B-operand select: 00 = register, 01 = immediate.
- EscReg  out  1  register file write enable.
- RegFonte  out  1  write-back source: 0 = ALU, 1 = memory.
- SelDest  out  1  destination register field select.
- EscPC  out  1  PC write enable.
- PCFonte  out  2  next PC source: 00 = PC+1, 01 = branch target, 10 = jump target.
- Parado  out  1  processor halted.
- Erro  out  1  sticky memory-timeout flag.
- Estado  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: BUSCA=0, DECODIFICA=1, EXECUTA=2, MEMORIA=3, ESCRITA=4, PARADO=5. Encodings 6 and 7 are illegal; on the next edge they go to PARADO with Erro=1.
- Reset: when rst_n=0 at a clk edge, the next state is BUSCA and op_reg=000, cont=0, Erro=0. Reset wins over every other event, including mid-access.
- Default output values: all control outputs are 0 unless listed for the state below. This also holds during reset and in the first cycle after it.

BUSCA:
- Drives IouD=0, LerMem=1.
- In the cycle MemPronta=1, also drives IREsc=1, EscPC=1, PCFonte=00 (Mealy outputs), then moves to DECODIFICA.
- Otherwise stays in BUSCA.

DECODIFICA:
- Lasts one cycle; op_reg <= Opcode.
- Next state is PARADO if Opcode=111, else EXECUTA.

EXECUTA (one cycle; decisions use op_reg):
- 000: ULAOp=10, ULAFonte=00, then ESCRITA.
- 100: ULAOp=11, ULAFonte=01, then ESCRITA.
- 110: ULAOp=01, ULAFonte=00, then ESCRITA.
- 001/010: ULAOp=00, ULAFonte=01 (address computation), then MEMORIA.
- 011: ULAOp=00, EscPC=Zero, PCFonte=01, then BUSCA.
- 101: EscPC=1, PCFonte=10, then BUSCA.

MEMORIA:
- Drives IouD=1 throughout.
- op 001: LerMem=1. On MemPronta=1, moves to ESCRITA.
- op 010: EscMem=1, SelDest=1. On MemPronta=1, moves to BUSCA.
- Otherwise stays in MEMORIA.

ESCRITA:
- Lasts one cycle; drives EscReg=1 and RegFonte = (op_reg==001), then BUSCA.

PARADO:
- Drives Parado=1 and all other control outputs 0. Exits only by reset.

Wait counter and timeout:
- cont is cleared on entry to BUSCA or MEMORIA.
- It increments each cycle spent in those states with MemPronta=0.
- If MemPronta=0 and cont==MAX_ESPERA-1, the next state is PARADO and Erro is set.
- MemPronta=1 in that same cycle completes the access normally; no error.

Latency with zero-wait memory (MemPronta held 1):
- ALU ops: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- beqz and jump: 3 cycles.
- Each wait cycle adds 1.

Invariants:
- LerMem and EscMem are never both 1.
- IREsc=1 only in BUSCA.
- Opcode changes after DECODIFICA have no effect.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release with MemPronta=1 and Opcode=000. Required: Estado=0 and all outputs 0 while in reset; then Estado sequence 0,1,2,4,0; EscReg=1 only in the ESCRITA cycle; ULAOp=10 in EXECUTA.
- Load with 2 wait states: Opcode=001, MemPronta low for 2 cycles in MEMORIA. Required: LerMem=1 and IouD=1 for 3 cycles; then ESCRITA with RegFonte=1, EscReg=1; total 7 cycles.
- beqz: Opcode=011. With Zero=1, EscPC=1 and PCFonte=01 in EXECUTA. With Zero=0, EscPC=0. Both cases return to BUSCA after 3 cycles.
- Jump and halt: Opcode=101 gives EscPC=1, PCFonte=10 in EXECUTA. Then Opcode=111 gives PARADO with Parado=1, staying there for 20 cycles despite MemPronta activity.
- Timeout: MAX_ESPERA=4, MemPronta=0 forever from reset. Required: LerMem=1 for 4 cycles, then Estado=5, Parado=1, Erro=1. Asserting rst_n=0 clears Erro.
- Reset mid-operation: rst_n=0 while in MEMORIA during a store. Required: EscMem=0 in the next cycle, Estado=0; the following fetch proceeds normally.

Source files
------------

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multi-cycle control FSM for the 3-bit-opcode processor
// Sequences fetch/decode/execute/memory/write-back over one shared handshaked memory port.
module controle_multiciclo #(
    parameter int MAX_ESPERA = 15,
    parameter int LARG_CONT  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] Opcode,
    input  logic       Zero,
    input  logic       MemPronta,
    output logic       IREsc,
    output logic       IouD,
    output logic       LerMem,
    output logic       EscMem,
    output logic [1:0] ULAOp,
    output logic [1:0] ULAFonte,
    output logic       EscReg,
    output logic       RegFonte,
    output logic       SelDest,
    output logic       EscPC,
    output logic [1:0] PCFonte,
    output logic       Parado,
    output logic       Erro,
    output logic [2:0] Estado
);

    localparam logic [2:0] BUSCA      = 3'd0;
    localparam logic [2:0] DECODIFICA = 3'd1;
    localparam logic [2:0] EXECUTA    = 3'd2;
    localparam logic [2:0] MEMORIA    = 3'd3;
    localparam logic [2:0] ESCRITA    = 3'd4;
    localparam logic [2:0] PARADO     = 3'd5;

    localparam logic [LARG_CONT-1:0] LIMITE = LARG_CONT'(MAX_ESPERA - 1);

    logic [2:0]           estadoAtual;
    logic [2:0]           proxEstado;
    logic [2:0]           opReg;
    logic [LARG_CONT-1:0] cont;
    logic                 erroReg;
    logic                 erroSet;
    logic                 esperando;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estadoAtual <= BUSCA;
            opReg       <= 3'b000;
            cont        <= '0;
            erroReg     <= 1'b0;
        end else begin
            estadoAtual <= proxEstado;
            if (estadoAtual == DECODIFICA)
                opReg <= Opcode;
            if (erroSet)
                erroReg <= 1'b1;
            // Counter only runs while an access stalls; any exit leaves it cleared for the next entry.
            cont <= esperando ? cont + 1'b1 : '0;
        end
    end

    always_comb begin
        proxEstado = estadoAtual;
        erroSet    = 1'b0;
        esperando  = 1'b0;
        case (estadoAtual)
            BUSCA: begin
                if (MemPronta)
                    proxEstado = DECODIFICA;
                else if (cont == LIMITE) begin
                    proxEstado = PARADO;
                    erroSet    = 1'b1;
                end else
                    esperando = 1'b1;
            end
            DECODIFICA: proxEstado = (Opcode == 3'b111) ? PARADO : EXECUTA;
            EXECUTA: begin
                case (opReg)
                    3'b000, 3'b100, 3'b110: proxEstado = ESCRITA;
                    3'b001, 3'b010:         proxEstado = MEMORIA;
                    3'b011, 3'b101:         proxEstado = BUSCA;
                    default:                proxEstado = PARADO;
                endcase
            end
            MEMORIA: begin
                if (MemPronta)
                    proxEstado = (opReg == 3'b001) ? ESCRITA : BUSCA;
                else if (cont == LIMITE) begin
                    proxEstado = PARADO;
                    erroSet    = 1'b1;
                end else
                    esperando = 1'b1;
            end
            ESCRITA: proxEstado = BUSCA;
            PARADO:  proxEstado = PARADO;
            default: begin
                proxEstado = PARADO;
                erroSet    = 1'b1;
            end
        endcase
    end

    always_comb begin
        IREsc    = 1'b0;
        IouD     = 1'b0;
        LerMem   = 1'b0;
        EscMem   = 1'b0;
        ULAOp    = 2'b00;
        ULAFonte = 2'b00;
        EscReg   = 1'b0;
        RegFonte = 1'b0;
        SelDest  = 1'b0;
        EscPC    = 1'b0;
        PCFonte  = 2'b00;
        Parado   = 1'b0;
        Erro     = rst_n & erroReg;
        Estado   = estadoAtual;
        // Holding reset silences every control net, even mid-access.
        if (rst_n) begin
            case (estadoAtual)
                BUSCA: begin
                    LerMem = 1'b1;
                    if (MemPronta) begin
                        IREsc = 1'b1;
                        EscPC = 1'b1;
                    end
                end
                EXECUTA: begin
                    case (opReg)
                        3'b000: ULAOp = 2'b10;
                        3'b100: begin
                            ULAOp    = 2'b11;
                            ULAFonte = 2'b01;
                        end
                        3'b110: ULAOp = 2'b01;
                        3'b001, 3'b010: ULAFonte = 2'b01;
                        3'b011: begin
                            EscPC   = Zero;
                            PCFonte = 2'b01;
                        end
                        3'b101: begin
                            EscPC   = 1'b1;
                            PCFonte = 2'b10;
                        end
                        default: ;
                    endcase
                end
                MEMORIA: begin
                    IouD = 1'b1;
                    if (opReg == 3'b001)
                        LerMem = 1'b1;
                    else if (opReg == 3'b010) begin
                        EscMem  = 1'b1;
                        SelDest = 1'b1;
                    end
                end
                ESCRITA: begin
                    EscReg   = 1'b1;
                    RegFonte = (opReg == 3'b001);
                end
                PARADO:  Parado = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - scoreboard bench for controle_multiciclo
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] Opcode = 3'b000;
    logic       Zero = 1'b0;
    logic       MemPronta = 1'b0;
    logic       IREsc, IouD, LerMem, EscMem, EscReg, RegFonte, SelDest, EscPC, Parado, Erro;
    logic [1:0] ULAOp, ULAFonte, PCFonte;
    logic [2:0] Estado;

    int checks = 0;
    int errors = 0;

    logic [18:0] expQ[$];
    string       tagQ[$];

    controle_multiciclo #(.MAX_ESPERA(4), .LARG_CONT(8)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemPronta(MemPronta),
        .IREsc(IREsc), .IouD(IouD), .LerMem(LerMem), .EscMem(EscMem),
        .ULAOp(ULAOp), .ULAFonte(ULAFonte), .EscReg(EscReg), .RegFonte(RegFonte),
        .SelDest(SelDest), .EscPC(EscPC), .PCFonte(PCFonte), .Parado(Parado),
        .Erro(Erro), .Estado(Estado)
    );

    always #5 clk = ~clk;

    // Vector layout: Estado[18:16] IREsc IouD LerMem EscMem ULAOp[11:10] ULAFonte[9:8]
    // EscReg RegFonte SelDest EscPC PCFonte[3:2] Parado Erro
    localparam logic [18:0] IR = 19'h1 << 15, ID = 19'h1 << 14, LM = 19'h1 << 13, EM = 19'h1 << 12;
    localparam logic [18:0] UO10 = 19'h2 << 10, UF01 = 19'h1 << 8;
    localparam logic [18:0] ER = 19'h1 << 7, RF = 19'h1 << 6, SD = 19'h1 << 5, EP = 19'h1 << 4;
    localparam logic [18:0] PF01 = 19'h1 << 2, PF10 = 19'h2 << 2, PA = 19'h1 << 1, EE = 19'h1;

    function automatic logic [18:0] st(input int s);
        return 19'(s) << 16;
    endfunction

    function automatic logic [18:0] observado();
        return {Estado, IREsc, IouD, LerMem, EscMem, ULAOp, ULAFonte,
                EscReg, RegFonte, SelDest, EscPC, PCFonte, Parado, Erro};
    endfunction

    // Drive one cycle's inputs at the falling edge, compare the popped expectation, advance.
    task automatic ciclo(input logic rn, input logic mp, input logic z, input logic [2:0] op,
                         input logic [18:0] esperado, input string tag);
        logic [18:0] e;
        string       t;
        logic [18:0] o;
        rst_n = rn; MemPronta = mp; Zero = z; Opcode = op;
        expQ.push_back(esperado);
        tagQ.push_back(tag);
        #1;
        e = expQ.pop_front();
        t = tagQ.pop_front();
        o = observado();
        checks++;
        assert (o === e) else begin
            errors++;
            $display("FAIL %s: observed %05h expected %05h", t, o, e);
            $error("check %s differs", t);
        end
        checks++;
        assert (!(LerMem && EscMem)) else begin
            errors++;
            $display("FAIL %s_excl: observed LerMem=%b EscMem=%b expected not both 1", t, LerMem, EscMem);
            $error("check %s_excl differs", t);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        ciclo(0, 1, 0, 3'b000, st(0), "reset1");
        ciclo(0, 1, 0, 3'b000, st(0), "reset2");

        // ALU op; opcode changes after decode must be ignored
        ciclo(1, 1, 0, 3'b000, st(0) | IR | LM | EP, "alu_busca");
        ciclo(1, 1, 0, 3'b000, st(1), "alu_dec");
        ciclo(1, 1, 0, 3'b001, st(2) | UO10, "alu_exec");
        ciclo(1, 1, 0, 3'b101, st(4) | ER, "alu_escrita");

        // Load with two wait states
        ciclo(1, 1, 0, 3'b001, st(0) | IR | LM | EP, "ld_busca");
        ciclo(1, 1, 0, 3'b001, st(1), "ld_dec");
        ciclo(1, 1, 0, 3'b001, st(2) | UF01, "ld_exec");
        ciclo(1, 0, 0, 3'b001, st(3) | ID | LM, "ld_mem_w1");
        ciclo(1, 0, 0, 3'b001, st(3) | ID | LM, "ld_mem_w2");
        ciclo(1, 1, 0, 3'b001, st(3) | ID | LM, "ld_mem_ok");
        ciclo(1, 1, 0, 3'b001, st(4) | ER | RF, "ld_escrita");

        // beqz taken then not taken
        ciclo(1, 1, 1, 3'b011, st(0) | IR | LM | EP, "bz1_busca");
        ciclo(1, 1, 1, 3'b011, st(1), "bz1_dec");
        ciclo(1, 1, 1, 3'b011, st(2) | EP | PF01, "bz1_exec");
        ciclo(1, 1, 0, 3'b011, st(0) | IR | LM | EP, "bz0_busca");
        ciclo(1, 1, 0, 3'b011, st(1), "bz0_dec");
        ciclo(1, 1, 0, 3'b011, st(2) | PF01, "bz0_exec");

        // Jump then halt
        ciclo(1, 1, 0, 3'b101, st(0) | IR | LM | EP, "jmp_busca");
        ciclo(1, 1, 0, 3'b101, st(1), "jmp_dec");
        ciclo(1, 1, 0, 3'b101, st(2) | EP | PF10, "jmp_exec");
        ciclo(1, 1, 0, 3'b111, st(0) | IR | LM | EP, "halt_busca");
        ciclo(1, 1, 0, 3'b111, st(1), "halt_dec");
        for (int i = 0; i < 20; i++)
            ciclo(1, logic'(i % 2), 0, 3'b000, st(5) | PA, $sformatf("halt_%0d", i));

        // Timeout during fetch
        ciclo(0, 0, 0, 3'b000, st(5), "to_rst1");
        ciclo(0, 0, 0, 3'b000, st(0), "to_rst2");
        for (int i = 0; i < 4; i++)
            ciclo(1, 0, 0, 3'b000, st(0) | LM, $sformatf("to_wait_%0d", i));
        ciclo(1, 0, 0, 3'b000, st(5) | PA | EE, "to_parado");
        ciclo(1, 1, 0, 3'b000, st(5) | PA | EE, "to_sticky");
        ciclo(0, 0, 0, 3'b000, st(5), "to_rst_gate");
        ciclo(0, 0, 0, 3'b000, st(0), "to_rst_clr");

        // Reset in the middle of a store
        ciclo(1, 1, 0, 3'b010, st(0) | IR | LM | EP, "st_busca");
        ciclo(1, 1, 0, 3'b010, st(1), "st_dec");
        ciclo(1, 1, 0, 3'b010, st(2) | UF01, "st_exec");
        ciclo(1, 0, 0, 3'b010, st(3) | ID | EM | SD, "st_mem");
        ciclo(0, 0, 0, 3'b010, st(3), "st_rst");
        ciclo(1, 1, 0, 3'b100, st(0) | IR | LM | EP, "pos_busca");
        ciclo(1, 1, 0, 3'b100, st(1), "pos_dec");
        ciclo(1, 1, 0, 3'b100, st(2) | (19'h3 << 10) | UF01, "pos_exec");
        ciclo(1, 1, 0, 3'b100, st(4) | ER, "pos_escrita");
        ciclo(1, 0, 0, 3'b100, st(0) | LM, "pos_busca2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
